// File: rtl/hamming15_link.sv
// hamming15_link: registered Hamming(15,11) single-error-correcting link.
// Stage 1 encodes an 11-bit word and optionally flips one codeword bit.
// Stage 2 computes the syndrome, corrects the flipped bit and extracts the data.
// Fixed 2-cycle latency, one word per cycle.
// Optional feature: define HAMMING_ERRCNT_EN to add a saturating 16-bit
// err_count output that counts corrected words.
module hamming15_link (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [10:0] data_in,
  input  logic [3:0]  err_pos,
  input  logic        err_en,
  output logic        out_valid,
  output logic [10:0] data_out,
  output logic [14:0] code_out,
  output logic [3:0]  syndrome,
  output logic        corrected
`ifdef HAMMING_ERRCNT_EN
  ,
  output logic [15:0] err_count
`endif
);

  // Code bit i holds position i+1. These masks select the code bits whose
  // position has syndrome bit k set, parity bits included.
  localparam logic [14:0] SYN_MASK0 = 15'h5555;
  localparam logic [14:0] SYN_MASK1 = 15'h6666;
  localparam logic [14:0] SYN_MASK2 = 15'h7878;
  localparam logic [14:0] SYN_MASK3 = 15'h7F80;

  logic [14:0] enc_code;
  logic [14:0] flip_mask;
  logic [14:0] inj_code;

  logic        s1_valid;
  logic [14:0] s1_code;

  logic [3:0]  syn_calc;
  logic [14:0] fix_mask;
  logic [14:0] fixed_code;
  logic [10:0] data_calc;

  // Encoder: place data at the non-power-of-two positions, then compute the
  // even-parity bits at positions 1, 2, 4 and 8.
  always_comb begin
    enc_code     = '0;
    enc_code[2]  = data_in[0];
    enc_code[4]  = data_in[1];
    enc_code[5]  = data_in[2];
    enc_code[6]  = data_in[3];
    enc_code[8]  = data_in[4];
    enc_code[9]  = data_in[5];
    enc_code[10] = data_in[6];
    enc_code[11] = data_in[7];
    enc_code[12] = data_in[8];
    enc_code[13] = data_in[9];
    enc_code[14] = data_in[10];
    enc_code[0]  = data_in[0] ^ data_in[1] ^ data_in[3] ^ data_in[4] ^
                   data_in[6] ^ data_in[8] ^ data_in[10];
    enc_code[1]  = data_in[0] ^ data_in[2] ^ data_in[3] ^ data_in[5] ^
                   data_in[6] ^ data_in[9] ^ data_in[10];
    enc_code[3]  = data_in[1] ^ data_in[2] ^ data_in[3] ^ data_in[7] ^
                   data_in[8] ^ data_in[9] ^ data_in[10];
    enc_code[7]  = data_in[4] ^ data_in[5] ^ data_in[6] ^ data_in[7] ^
                   data_in[8] ^ data_in[9] ^ data_in[10];
  end

  // Error injector: a one-hot flip mask decoded from err_pos; position 0
  // matches no code bit, so it never flips anything.
  always_comb begin
    flip_mask = '0;
    for (int i = 0; i < 15; i++) begin
      flip_mask[i] = err_en && (err_pos == 4'(i + 1));
    end
    inj_code = enc_code ^ flip_mask;
  end

  // Stage-1 register: the transmitted codeword, held while no word arrives.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_code  <= '0;
    end else begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_code <= inj_code;
      end
    end
  end

  // Decoder: syndrome gives the position of a single flipped bit, which is
  // inverted back before the data bits are pulled out again.
  always_comb begin
    syn_calc[0] = ^(s1_code & SYN_MASK0);
    syn_calc[1] = ^(s1_code & SYN_MASK1);
    syn_calc[2] = ^(s1_code & SYN_MASK2);
    syn_calc[3] = ^(s1_code & SYN_MASK3);
    fix_mask = '0;
    for (int i = 0; i < 15; i++) begin
      fix_mask[i] = (syn_calc == 4'(i + 1));
    end
    fixed_code    = s1_code ^ fix_mask;
    data_calc     = '0;
    data_calc[0]  = fixed_code[2];
    data_calc[1]  = fixed_code[4];
    data_calc[2]  = fixed_code[5];
    data_calc[3]  = fixed_code[6];
    data_calc[4]  = fixed_code[8];
    data_calc[5]  = fixed_code[9];
    data_calc[6]  = fixed_code[10];
    data_calc[7]  = fixed_code[11];
    data_calc[8]  = fixed_code[12];
    data_calc[9]  = fixed_code[13];
    data_calc[10] = fixed_code[14];
  end

  // Output register: decoded results, held while the pipeline carries no word.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      data_out  <= '0;
      code_out  <= '0;
      syndrome  <= '0;
      corrected <= 1'b0;
    end else begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        data_out  <= data_calc;
        code_out  <= s1_code;
        syndrome  <= syn_calc;
        corrected <= (syn_calc != 4'd0);
      end
    end
  end

`ifdef HAMMING_ERRCNT_EN
  // Corrected-word counter: counts presented corrections, sticks at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_count <= '0;
    end else if (out_valid && corrected && (err_count != 16'hFFFF)) begin
      err_count <= err_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hamming15_link.sv
// tb_hamming15_link: directed checks of hamming15_link plus a full
// data x error-position sweep; prints a single summary line.
module tb_hamming15_link;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [10:0] data_in;
  logic [3:0]  err_pos;
  logic        err_en;
  logic        out_valid;
  logic [10:0] data_out;
  logic [14:0] code_out;
  logic [3:0]  syndrome;
  logic        corrected;
`ifdef HAMMING_ERRCNT_EN
  logic [15:0] err_count;
`endif

  int test_count;
  int fail_count;

  hamming15_link dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .data_in   (data_in),
    .err_pos   (err_pos),
    .err_en    (err_en),
    .out_valid (out_valid),
    .data_out  (data_out),
    .code_out  (code_out),
    .syndrome  (syndrome),
    .corrected (corrected)
`ifdef HAMMING_ERRCNT_EN
    ,
    .err_count (err_count)
`endif
  );

  // Free-running clock, 10 time units per cycle.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value with its expected value and count it.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    test_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Reference encoder built from the parity definition: walk positions,
  // fill data slots in order, then set each parity bit to cover its group.
  function automatic logic [14:0] encodeModel(input logic [10:0] d);
    logic [14:0] c;
    int j;
    logic par;
    c = '0;
    j = 0;
    for (int p = 1; p <= 15; p++) begin
      if ((p & (p - 1)) != 0) begin
        c[p-1] = d[j];
        j++;
      end
    end
    for (int k = 0; k < 4; k++) begin
      par = 1'b0;
      for (int p = 1; p <= 15; p++) begin
        if (((p >> k) & 1) == 1) par = par ^ c[p-1];
      end
      c[(1 << k) - 1] = par;
    end
    return c;
  endfunction

  // Send one word alone and wait until it reaches the outputs.
  task automatic applyStimulus(input logic [10:0] d, input logic [3:0] pos,
                               input logic en);
    data_in  = d;
    err_pos  = pos;
    err_en   = en;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  logic [10:0] q_data[$];
  logic [3:0]  q_pos[$];
  logic [10:0] exp_data;
  logic [3:0]  exp_pos;
  logic [14:0] exp_code;

  initial begin
    test_count = 0;
    fail_count = 0;
    rst      = 1'b1;
    in_valid = 1'b0;
    data_in  = '0;
    err_pos  = '0;
    err_en   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset data_out", 32'(data_out), 32'd0);
    checkOutput("reset code_out", 32'(code_out), 32'd0);
    checkOutput("reset syndrome", 32'(syndrome), 32'd0);
    checkOutput("reset corrected", 32'(corrected), 32'd0);
    rst = 1'b0;

    // Clean word: parity at positions 1 and 2 cover position 3.
    applyStimulus(11'h001, 4'd0, 1'b0);
    checkOutput("clean out_valid", 32'(out_valid), 32'd1);
    checkOutput("clean code_out", 32'(code_out), 32'h0007);
    checkOutput("clean syndrome", 32'(syndrome), 32'd0);
    checkOutput("clean corrected", 32'(corrected), 32'd0);
    checkOutput("clean data_out", 32'(data_out), 32'h001);

    // Single flip at position 5.
    applyStimulus(11'h001, 4'd5, 1'b1);
    checkOutput("pos5 code_out", 32'(code_out), 32'h0017);
    checkOutput("pos5 syndrome", 32'(syndrome), 32'd5);
    checkOutput("pos5 corrected", 32'(corrected), 32'd1);
    checkOutput("pos5 data_out", 32'(data_out), 32'h001);

    // Position 0 with injection enabled never flips.
    applyStimulus(11'h7FF, 4'd0, 1'b1);
    checkOutput("pos0 code_out", 32'(code_out), 32'h7FFF);
    checkOutput("pos0 syndrome", 32'(syndrome), 32'd0);
    checkOutput("pos0 corrected", 32'(corrected), 32'd0);
    checkOutput("pos0 data_out", 32'(data_out), 32'h7FF);

    // Position given but injection disabled.
    applyStimulus(11'h000, 4'd9, 1'b0);
    checkOutput("noen code_out", 32'(code_out), 32'h0000);
    checkOutput("noen syndrome", 32'(syndrome), 32'd0);
    checkOutput("noen data_out", 32'(data_out), 32'h000);

    // Outputs hold when no word is presented.
    @(posedge clk);
    #1;
    checkOutput("idle out_valid", 32'(out_valid), 32'd0);
    checkOutput("idle code_out hold", 32'(code_out), 32'h0000);

    // Reset with words in flight, then the first word after reset.
    data_in  = 11'h555;
    err_pos  = 4'd3;
    err_en   = 1'b1;
    in_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("midrst out_valid", 32'(out_valid), 32'd0);
    checkOutput("midrst data_out", 32'(data_out), 32'd0);
    checkOutput("midrst code_out", 32'(code_out), 32'd0);
    checkOutput("midrst syndrome", 32'(syndrome), 32'd0);
    checkOutput("midrst corrected", 32'(corrected), 32'd0);
`ifdef HAMMING_ERRCNT_EN
    checkOutput("midrst err_count", 32'(err_count), 32'd0);
`endif
    rst      = 1'b0;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("drain out_valid", 32'(out_valid), 32'd0);
    data_in  = 11'h2A5;
    err_pos  = 4'd0;
    err_en   = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    checkOutput("first 1cyc out_valid", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    checkOutput("first 2cyc out_valid", 32'(out_valid), 32'd1);
    checkOutput("first data_out", 32'(data_out), 32'h2A5);
    checkOutput("first code_out", 32'(code_out), 32'(encodeModel(11'h2A5)));

    // Back-to-back sweep of every word against every error position.
    for (int d = 0; d < 2048; d++) begin
      for (int p = 1; p <= 15; p++) begin
        data_in  = 11'(d);
        err_pos  = 4'(p);
        err_en   = 1'b1;
        in_valid = 1'b1;
        q_data.push_back(11'(d));
        q_pos.push_back(4'(p));
        @(posedge clk);
        #1;
        if (q_data.size() == 2) begin
          exp_data = q_data.pop_front();
          exp_pos  = q_pos.pop_front();
          exp_code = encodeModel(exp_data);
          exp_code[exp_pos - 4'd1] = ~exp_code[exp_pos - 4'd1];
          checkOutput("sweep out_valid", 32'(out_valid), 32'd1);
          checkOutput("sweep data_out", 32'(data_out), 32'(exp_data));
          checkOutput("sweep syndrome", 32'(syndrome), 32'(exp_pos));
          checkOutput("sweep corrected", 32'(corrected), 32'd1);
          checkOutput("sweep code_out", 32'(code_out), 32'(exp_code));
        end
      end
    end
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    exp_data = q_data.pop_front();
    exp_pos  = q_pos.pop_front();
    checkOutput("sweep last data_out", 32'(data_out), 32'(exp_data));
    checkOutput("sweep last syndrome", 32'(syndrome), 32'(exp_pos));
    @(posedge clk);
    #1;
    checkOutput("post sweep out_valid", 32'(out_valid), 32'd0);
`ifdef HAMMING_ERRCNT_EN
    checkOutput("sweep err_count", 32'(err_count), 32'd30720);
`endif

    $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
    $finish;
  end

endmodule

// File: doc/hamming15_link.md
Name: hamming15_link

Overview:
- Registered Hamming(15,11) single-error-correcting link.
- Stage 1 encodes an 11-bit word into a 15-bit codeword and optionally flips one codeword bit, the injected channel error.
- Stage 2 computes the syndrome, corrects the codeword and extracts the 11 data bits.
- Used as a self-checking ECC datapath: one word per cycle, fixed 2-cycle latency.

Parameters:
- None. Widths are fixed at 11 data bits, 15 code bits and a 4-bit position.

Ports:
- clk  input  1  system clock; all state changes on the rising edge
- rst  input  1  synchronous reset, active-high
- in_valid  input  1  data_in/err_pos/err_en are sampled this cycle
- data_in  input  11  data word to encode
- err_pos  input  4  codeword position (1..15) to flip; 0 means no flip
- err_en  input  1  1 enables error injection at err_pos
- out_valid  output  1  outputs below are valid this cycle
- data_out  output  11  corrected data word
- code_out  output  15  codeword as transmitted, after injection (bit i = position i+1)
- syndrome  output  4  computed syndrome (0 = no error detected)
- corrected  output  1  1 when syndrome != 0 and a bit was flipped back

Behaviour:
- Reset: every register clears to 0, so out_valid, data_out, code_out, syndrome and corrected all read 0. Any in-flight words are discarded.
- Codeword layout: position p (1..15) is code bit p-1. Parity bits sit at positions 1, 2, 4 and 8.
- Data mapping: data_in[0..10] go to positions 3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15, in that order.
- Parity bit at position 2^k = even-parity XOR of all data positions whose index has bit k set.
- Injection: if err_en=1 and err_pos!=0, invert code bit err_pos-1. Otherwise the codeword passes unchanged; err_pos=0 never flips a bit.
- Syndrome bit k = XOR of all code bits whose position has bit k set, parity included.
- Correction: if syndrome != 0, invert bit syndrome-1 and set corrected=1. Then extract data using the inverse of the data mapping.
- Pipeline, edge k (in_valid=1): stage-1 register captures the injected codeword and valid=1.
- Pipeline, edge k+1: output registers capture data_out, syndrome, corrected and code_out (the stage-1 codeword), and out_valid=1.
- Latency is exactly 2 cycles. Throughput is 1 word/cycle with no stalls and no back-pressure.
- in_valid=0: the valid bit propagates as 0. Data registers hold their previous contents; consumers must qualify them with out_valid.
- Double errors cannot be produced by the injector and are not detected. Behaviour on multi-bit corruption is mis-correction per the syndrome, with no flag.
- All encode, inject and decode logic is combinational between the two register stages.

Optional Feature:
- Macro HAMMING_ERRCNT_EN.
- Defined: adds output err_count (16 bits).
  - Cleared by rst.
  - Increments by 1 on each cycle where out_valid=1 and corrected=1.
  - Saturates at 0xFFFF and does not wrap.
- Not defined: the port and the counter logic are absent. All other behaviour is identical.

Test Plan:
- data_in=0x001, err_en=0 -> after 2 cycles: code_out=0x0007, syndrome=0, corrected=0, data_out=0x001, out_valid=1.
- data_in=0x001, err_pos=5, err_en=1 -> code_out=0x0017, syndrome=5, corrected=1, data_out=0x001.
- data_in=0x7FF, err_pos=0, err_en=1 -> code_out=0x7FFF, syndrome=0, corrected=0, data_out=0x7FF (position 0 is never flipped).
- data_in=0x000, err_pos=9, err_en=0 -> code_out=0x0000, syndrome=0, data_out=0x000.
- Exhaustive sweep: all 2048 data words × err_pos 1..15 with err_en=1, back-to-back one per cycle. Required each time: data_out equals the word sent 2 cycles earlier, syndrome=err_pos, corrected=1. Under HAMMING_ERRCNT_EN, err_count=30720 at the end.
- Assert rst while words are in flight -> out_valid=0 and all outputs 0 on the following cycle. The first valid word after reset appears exactly 2 cycles after its in_valid.
